// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: single-port word RAM behind a valid/ready request and one-cycle response pulse.
// Optional misaligned-address fault reporting when RISCV_MEM_MISALIGN_CHECK_EN is defined.
module riscv_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, be_q, be_d;
  logic write_q, write_d, err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0] off_q, off_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, fire, fault, unused_addr;
  assign accept = state_q == IDLE && req_valid;
  assign fire = state_q == ACCESS && cnt_q == 4'd0;
`ifdef RISCV_MEM_MISALIGN_CHECK_EN
  assign fault = off_q != 2'b00;
`else
  assign fault = 1'b0;
`endif
  // upper address bits alias the array; low bits matter only for the fault check
  assign unused_addr = ^{req_addr[31:AW+2], off_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    state_d = accept ? ACCESS : fire ? RESP : state_q == RESP ? IDLE : state_q;
  end
  always_comb begin
    req_ready = state_q == IDLE && !rst;
    rsp_valid = state_q == RESP;
    rsp_err   = state_q == RESP && err_q;
    rsp_rdata = rdata_q;
  end
  always_comb begin
    write_d = accept ? req_write : write_q;
    idx_d   = accept ? req_addr[AW+1:2] : idx_q;
    off_d   = accept ? req_addr[1:0] : off_q;
    wdata_d = accept ? req_wdata : wdata_q;
    be_d    = accept ? req_be : be_q;
    cnt_d   = accept ? 4'(WAIT_CYCLES) : (state_q == ACCESS && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    rdata_d = !fire ? rdata_q : fault ? 32'd0 : write_q ? rdata_q : mem[idx_q];
    err_d   = fire ? fault : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fire && write_q && !fault)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb_riscv_mem_responder: table vectors, corner sequences and randomized traffic against a word-array model.
module tb_riscv_mem_responder;
`ifdef RISCV_MEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] rd;
    bit          e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] rv, rw, rdy, rsv, rse;
  logic [31:0] ra [2];
  logic [31:0] rwd [2];
  logic [31:0] rrd [2];
  logic [3:0]  rbe [2];
  logic [31:0] mm [1024];
  logic [31:0] last_rd;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .req_be(rbe[0]),
    .rsp_valid(rsv[0]), .rsp_rdata(rrd[0]), .rsp_err(rse[0]));
  riscv_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .req_be(rbe[1]),
    .rsp_valid(rsv[1]), .rsp_rdata(rrd[1]), .rsp_err(rse[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Starts at a falling edge; returns at a falling edge with the responder idle again.
  task automatic do_req(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic e);
    int n;
    bit bad;
    n = 0;
    bad = 1'b0;
    while (rdy[u] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(rdy[u]), 32'd1);
    rv[u] = 1'b1; rw[u] = w; ra[u] = a; rwd[u] = d; rbe[u] = be;
    @(posedge clk); #1;
    rv[u] = 1'b0; rw[u] = 1'($urandom_range(0, 1)); ra[u] = $urandom; rwd[u] = $urandom; rbe[u] = 4'($urandom);
    n = 0;
    while (rsv[u] !== 1'b1 && n < 50) begin
      bad |= (rdy[u] !== 1'b0);
      @(posedge clk); #1;
      n++;
    end
    bad |= (rdy[u] !== 1'b0);
    chk("latency", 32'(n), (u == 0) ? 32'd1 : 32'd3);
    chk("ready_low", 32'(bad), 32'd0);
    rd = rrd[u];
    e = rse[u];
    @(posedge clk); #1;
    chk("rsp_pulse", 32'(rsv[u]), 32'd0);
    @(negedge clk);
  endtask

  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rd, output logic e);
    int i;
    i = int'((a / 4) % 1024);
    e = MIS && (a % 4 != 0);
    if (e) last_rd = 32'd0;
    else if (w) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mm[i][8*k +: 8] = d[8*k +: 8];
    end else last_rd = mm[i];
    rd = last_rd;
  endtask

  task automatic run(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] rd, xr;
    logic e, xe;
    do_req(1, w, a, d, be, rd, e);
    model(w, a, d, be, xr, xe);
    chk("rand_rdata", rd, xr);
    chk("rand_err", 32'(e), 32'(xe));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    logic [31:0] rd, xr;
    logic e, xe;
    int acc [$];
    int stray;
    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0};
    tbl[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[7]  = '{1'b1, 32'h4,    32'hCAFEF00D, 4'hF, 32'h11BB33DD, 1'b0};
    tbl[8]  = '{1'b0, 32'h1004, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    tbl[9]  = '{1'b1, 32'h40,   32'h55AA55AA, 4'hF, 32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b0, 32'h13,   32'h0,        4'h0, MIS ? 32'h0 : 32'hDEADBEEF, MIS};
    tbl[11] = '{1'b1, 32'h42,   32'h12345678, 4'hF, MIS ? 32'h0 : 32'hDEADBEEF, MIS};
    tbl[12] = '{1'b0, 32'h40,   32'h0,        4'h0, MIS ? 32'h55AA55AA : 32'h12345678, 1'b0};
    rv = 2'b00; rw = 2'b00; last_rd = 32'd0;
    for (int u = 0; u < 2; u++) begin
      ra[u] = 32'd0; rwd[u] = 32'd0; rbe[u] = 4'd0;
    end
    // asynchronous reset in the middle of a low clock phase
    #3 rst = 1'b1;
    #1;
    chk("reset_rsp_valid", 32'(rsv[1]), 32'd0);
    chk("reset_rdata", rrd[1], 32'd0);
    chk("reset_err", 32'(rse[1]), 32'd0);
    chk("reset_ready", 32'(rdy[1]), 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_ready_held", 32'(rdy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(rdy), 32'd3);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      do_req(1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, rd, e);
      model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, xr, xe);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
    end

    // zero wait states: single-edge latency and one accept every three cycles
    do_req(0, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, rd, e);
    do_req(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, e);
    chk("w0_rdata", rd, 32'h0BADF00D);
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h8;
    for (int c = 0; c < 10; c++) begin
      if (rdy[0]) acc.push_back(c);
      @(negedge clk);
    end
    rv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("w0_accepts", 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++) chk("w0_spacing", 32'(acc[i] - acc[i-1]), 32'd3);

    // reset during ACCESS discards the pending store
    run(1'b1, 32'h30, 32'h0, 4'hF);
    rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 32'h30; rwd[1] = 32'h5; rbe[1] = 4'hF;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsv[1]), 32'd0);
    chk("midrst_ready", 32'(rdy[1]), 32'd0);
    last_rd = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsv[1] !== 1'b0) stray++;
      @(negedge clk);
    end
    chk("midrst_stray_rsp", 32'(stray), 32'd0);
    do_req(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, e);
    model(1'b0, 32'h30, 32'h0, 4'h0, xr, xe);
    chk("midrst_read", rd, 32'h0);

    for (int i = 0; i < 16; i++) run(1'b1, 32'(i * 4), $urandom, 4'hF);
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      run(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
Memory-side responder for the multi-cycle core's single unified instruction/data memory port. It accepts one request at a time from the core (fetch, load or store) using a valid/ready handshake. After a programmable number of wait states it performs a word-wide access with byte-lane write enables, then returns a one-cycle response pulse. It sits between the core's address/write-data/byte-enable outputs and a synchronous word-organised RAM array held inside this block.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
WAIT_CYCLES, 2, extra wait states per access; legal range 0..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  core presents a request this cycle
req_ready  out  1  responder can accept a request this cycle
req_write  in  1  1 = store, 0 = read (fetch or load)
req_addr  in  32  byte address
req_wdata  in  32  store data, already lane-aligned by the core
req_be  in  4  byte-lane write enables; bit i covers bits [8i+7:8i]
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  32  read word; held until the next response
rsp_err  out  1  access fault; qualified by rsp_valid

Behaviour:
- The clock is clk. The reset is rst, asynchronous and active-high.
- Reset state:
  - state = IDLE.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Wait counter = 0.
  - req_ready is forced 0 while rst is high.
  - RAM contents are not reset.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On a clock edge with req_valid = 1, latch req_write, req_addr, req_wdata and req_be.
  - Load the counter with WAIT_CYCLES and go to ACCESS.
- ACCESS:
  - req_ready = 0.
  - While the counter is nonzero, decrement it each edge.
  - On the edge where the counter is 0, perform the access and go to RESP.
    - Write: the RAM commits only the lanes whose req_be bit is set. be = 0 is a no-op write that still produces a response.
    - Read: rsp_rdata <= the full word, regardless of be.
- RESP:
  - rsp_valid = 1 for exactly one cycle; req_ready = 0.
  - Next edge goes to IDLE unconditionally. There is no response backpressure.
- Latency: a request accepted at edge E0 gives rsp_valid high in the cycle following edge E0+WAIT_CYCLES+1.
  - Example: WAIT_CYCLES=2, accept at edge 0 → rsp_valid high between edges 3 and 4.
- Throughput: one request per WAIT_CYCLES+3 cycles. The earliest next accept is the first IDLE cycle after RESP.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so the array aliases (wraps) modulo DEPTH_WORDS*4 bytes.
- A read issued after a write to the same word returns the written data, merged per byte lane.
- rsp_rdata keeps its last value through write responses and idle cycles. It updates only on read completion, or on a fault when the feature is enabled.
- Input changes while req_ready = 0 are ignored; the latched copy is used.
- Reset mid-operation:
  - An access not yet committed is discarded: no RAM write and no response.
  - The FSM returns to IDLE immediately.

Optional Feature:
Macro: RISCV_MEM_MISALIGN_CHECK_EN
- Defined:
  - A latched address with addr[1:0] != 2'b00 is a fault.
  - On a fault the write is suppressed and rsp_rdata <= 0.
  - rsp_err = 1 during the RESP cycle. Timing is unchanged.
- Not defined:
  - addr[1:0] is ignored. Accesses are word-aligned implicitly.
  - rsp_err is tied 0.

Test Plan:
- Reset then idle: assert rst mid-cycle (asynchronously) → rsp_valid=0, rsp_rdata=0, req_ready=0 while rst is high, req_ready=1 one cycle after release.
- Full write/read with WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10.
  - Expect rsp_valid exactly 3 edges after each accept, rsp_rdata=0xDEADBEEF, and req_ready low from accept through RESP.
- Byte-lane merge:
  - Word 0x20 = 0x11223344; write 0xAABBCCDD with be=4'b0101; read back.
  - Expect 0x11BB33DD. A write with be=0 leaves the word unchanged and still pulses rsp_valid.
- Aliasing with DEPTH_WORDS=1024:
  - Write 0x0000_0004, read 0x0000_1004 → same data.
  - WAIT_CYCLES=0: rsp_valid 1 edge after accept, and back-to-back requests are accepted every 3 cycles.
- Reset mid-access: write 0x5 to 0x30 (old value 0x0), assert rst during ACCESS, release, read 0x30 → 0x0 and no stray rsp_valid.
- Feature on:
  - Read 0x13 → rsp_err=1, rsp_rdata=0.
  - Write 0x32 → rsp_err=1 and the word is unchanged.
  - Aligned access → rsp_err=0.
- Feature off: the same misaligned read of 0x13 returns the word at 0x10 with rsp_err=0.
